// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter for the 8-bit processor fetch stage.
// Next-PC sources are sequential, PC-relative branch, absolute jump, and
// call/return through a circular return-address stack.
// Optional build macro PC_SEQ_RAS_EN: when defined the return-address stack is
// present; when undefined, call acts as jump, ret is ignored and both RAS
// flags are tied low.
module pc_sequencer #(
   parameter int PC_WIDTH  = 8,
   parameter int RESET_PC  = 0,
   parameter int RAS_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                stall,
   input  logic                branch_taken,
   input  logic                jump,
   input  logic                call,
   input  logic                ret,
   input  logic [PC_WIDTH-1:0] offset,
   input  logic [PC_WIDTH-1:0] jump_target,
   output logic [PC_WIDTH-1:0] pc,
   output logic [PC_WIDTH-1:0] next_pc,
   output logic                ras_overflow,
   output logic                ras_underflow
);

   logic [PC_WIDTH-1:0] pc_q;
   logic [PC_WIDTH-1:0] pc_d;
   logic [PC_WIDTH-1:0] seq_pc;

   // Sequential successor, also the return address a call pushes.
   // Offset is same-width two's complement, so plain modulo addition
   // gives sign extension for free.
   assign seq_pc = pc_q + PC_WIDTH'(1);

`ifdef PC_SEQ_RAS_EN
   localparam int PTR_W = $clog2(RAS_DEPTH);

   logic [PC_WIDTH-1:0] ras_mem_q [RAS_DEPTH];
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [PTR_W:0]      count_q, count_d;
   logic                ovf_q, ovf_d;
   logic                unf_q, unf_d;
   logic                ras_empty;
   logic                ras_full;
   logic                do_push;
   logic [PC_WIDTH-1:0] ras_top;

   // ptr_q is the slot the next push writes; the top entry sits just below it.
   // When full, ptr_q also points at the oldest entry, so a push overwrites it.
   assign ras_empty = (count_q == '0);
   assign ras_full  = (count_q == (PTR_W+1)'(RAS_DEPTH));
   assign ras_top   = ras_mem_q[ptr_q - PTR_W'(1)];

   // Next-PC priority (ret > call/jump > branch > sequential) and RAS next state.
   always_comb begin
      next_pc = seq_pc;
      ptr_d   = ptr_q;
      count_d = count_q;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      do_push = 1'b0;
      if (ret) begin
         if (ras_empty) begin
            next_pc = seq_pc;
            unf_d   = 1'b1;
         end else begin
            next_pc = ras_top;
            ptr_d   = ptr_q - PTR_W'(1);
            count_d = count_q - (PTR_W+1)'(1);
         end
      end else if (call) begin
         next_pc = jump_target;
         do_push = 1'b1;
         ptr_d   = ptr_q + PTR_W'(1);
         if (ras_full) begin
            ovf_d = 1'b1;
         end else begin
            count_d = count_q + (PTR_W+1)'(1);
         end
      end else if (jump) begin
         next_pc = jump_target;
      end else if (branch_taken) begin
         next_pc = seq_pc + offset;
      end
      // A stalled edge holds everything and emits no flags.
      pc_d = next_pc;
      if (stall) begin
         pc_d    = pc_q;
         ptr_d   = ptr_q;
         count_d = count_q;
         ovf_d   = 1'b0;
         unf_d   = 1'b0;
         do_push = 1'b0;
      end
   end

   // PC, stack pointer, occupancy and one-cycle flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= PC_WIDTH'(RESET_PC);
         ptr_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         ptr_q   <= ptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Stack storage; validity is tracked by count_q, so data needs no reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         ras_mem_q[ptr_q] <= seq_pc;
      end
   end

   assign ras_overflow  = ovf_q;
   assign ras_underflow = unf_q;
`else
   localparam int unused_ras_depth = RAS_DEPTH;
   logic unused_ret;
   assign unused_ret = ret;

   // Next-PC priority without a stack: call is a plain jump, ret is ignored.
   always_comb begin
      next_pc = seq_pc;
      if (call || jump) begin
         next_pc = jump_target;
      end else if (branch_taken) begin
         next_pc = seq_pc + offset;
      end
      pc_d = stall ? pc_q : next_pc;
   end

   // PC register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= PC_WIDTH'(RESET_PC);
      end else begin
         pc_q <= pc_d;
      end
   end

   assign ras_overflow  = 1'b0;
   assign ras_underflow = 1'b0;
`endif

   assign pc = pc_q;

endmodule
